multicycle_ctrl: RTL

Control FSM for the multicycle 32-bit datapath. It sequences instruction fetch, decode, execute, memory access and write-back, and emits every datapath enable and select. Its `PCSource` output drives the select of the PC-source `Mux4to1_32b`, and `ALUSrcB` drives the select of the ALU-B `Mux4to1_32b`. It sits upstream of both muxes and is the only producer of their select lines.

---
 rtl/multicycle_ctrl_pkg.sv | 44 ++++
 rtl/multicycle_ctrl_op_dispatch.sv | 23 ++
 rtl/multicycle_ctrl.sv | 130 +++++++++++++
 3 files changed

// File: rtl/multicycle_ctrl_pkg.sv
// Shared control definitions: state codes, opcodes and the mux/ALU select encodings
// that the datapath mux instances also decode.
`ifndef CTRL_DEFS_VH
`define CTRL_DEFS_VH
package multicycle_ctrl_pkg;

  typedef enum logic [3:0] {
    ST_RESET    = 4'd0,
    ST_FETCH    = 4'd1,
    ST_DECODE   = 4'd2,
    ST_MEM_ADDR = 4'd3,
    ST_MEM_RD   = 4'd4,
    ST_MEM_WB   = 4'd5,
    ST_MEM_WR   = 4'd6,
    ST_R_EX     = 4'd7,
    ST_R_WB     = 4'd8,
    ST_BRANCH   = 4'd9,
    ST_JUMP     = 4'd10,
    ST_I_EX     = 4'd11,
    ST_I_WB     = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  localparam logic [1:0] ALUB_B       = 2'b00;
  localparam logic [1:0] ALUB_4       = 2'b01;
  localparam logic [1:0] ALUB_IMM     = 2'b10;
  localparam logic [1:0] ALUB_IMM_SH2 = 2'b11;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

endpackage
`endif

// File: rtl/multicycle_ctrl_op_dispatch.sv
// DECODE-state dispatch: maps the opcode to the next state and flags unknown opcodes.
module op_dispatch
  import multicycle_ctrl_pkg::*;
(
  input  logic [5:0] op,
  output state_t     next,
  output logic       illegal
);

  always_comb begin
    next    = ST_FETCH;
    illegal = 1'b0;
    case (op)
      OP_LW, OP_SW: next = ST_MEM_ADDR;
      OP_RTYPE:     next = ST_R_EX;
      OP_BEQ:       next = ST_BRANCH;
      OP_J:         next = ST_JUMP;
      OP_ADDI:      next = ST_I_EX;
      default:      illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle datapath control FSM: state register, sequencing and per-state
// decode of every datapath enable and select.
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] Op,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       MemtoReg,
  output logic       RegDst,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [1:0] PCSource,
  output logic       illegal_op,
  output logic [3:0] state_o
);

  state_t state, state_nxt, dec_nxt;
  logic   dec_illegal;

  op_dispatch u_dispatch (
    .op      (Op),
    .next    (dec_nxt),
    .illegal (dec_illegal)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= ST_RESET;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = ST_RESET;
    case (state)
      ST_RESET:    state_nxt = ST_FETCH;
      ST_FETCH:    state_nxt = mem_ready ? ST_DECODE : ST_FETCH;
      ST_DECODE:   state_nxt = dec_nxt;
      ST_MEM_ADDR: state_nxt = (Op == OP_LW) ? ST_MEM_RD : ST_MEM_WR;
      ST_MEM_RD:   state_nxt = mem_ready ? ST_MEM_WB : ST_MEM_RD;
      ST_MEM_WB:   state_nxt = ST_FETCH;
      ST_MEM_WR:   state_nxt = mem_ready ? ST_FETCH : ST_MEM_WR;
      ST_R_EX:     state_nxt = ST_R_WB;
      ST_R_WB:     state_nxt = ST_FETCH;
      ST_BRANCH:   state_nxt = ST_FETCH;
      ST_JUMP:     state_nxt = ST_FETCH;
      ST_I_EX:     state_nxt = ST_I_WB;
      ST_I_WB:     state_nxt = ST_FETCH;
      default:     state_nxt = ST_RESET;
    endcase
  end

  // Selects come straight from the state so they never glitch within a cycle;
  // only the FETCH loads are qualified by mem_ready.
  always_comb begin
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    MemtoReg    = 1'b0;
    RegDst      = 1'b0;
    RegWrite    = 1'b0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = ALUB_B;
    ALUOp       = ALUOP_ADD;
    PCSource    = PCSRC_ALU;
    illegal_op  = 1'b0;
    case (state)
      ST_FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = ALUB_4;
        IRWrite = mem_ready;
        PCWrite = mem_ready;
      end
      ST_DECODE: begin
        ALUSrcB    = ALUB_IMM_SH2;
        illegal_op = dec_illegal;
      end
      ST_MEM_ADDR, ST_I_EX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = ALUB_IMM;
      end
      ST_MEM_RD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
      end
      ST_MEM_WB: begin
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
      end
      ST_MEM_WR: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
      end
      ST_R_EX: begin
        ALUSrcA = 1'b1;
        ALUOp   = ALUOP_FUNCT;
      end
      ST_R_WB: begin
        RegWrite = 1'b1;
        RegDst   = 1'b1;
      end
      ST_BRANCH: begin
        ALUSrcA     = 1'b1;
        ALUOp       = ALUOP_SUB;
        PCWriteCond = 1'b1;
        PCSource    = PCSRC_ALUOUT;
      end
      ST_JUMP: begin
        PCWrite  = 1'b1;
        PCSource = PCSRC_JUMP;
      end
      ST_I_WB: RegWrite = 1'b1;
      default: ;
    endcase
  end

  assign state_o = state;

endmodule
